// File: rtl/pairing_host_loader_pkg.sv
// Shared types for the pairing-core host loader. BRAM_DEPTH and redundant_poly_L3
// mirror the curve package values so this slice builds on its own.
package pairing_host_loader_pkg;

  localparam int BRAM_DEPTH = 8;
  localparam int ADDR_W     = BRAM_DEPTH + 1;
  localparam int POLY_W     = 48;

  typedef logic [POLY_W-1:0] redundant_poly_L3;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } host_state_t;

endpackage

// File: rtl/pairing_host_loader_sync_fifo.sv
// Small first-word-fall-through FIFO used as the result skid buffer.
// Head data is forced to zero while empty so the stream bus idles at 0.
module sync_fifo
  import pairing_host_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_push,
  input  redundant_poly_L3       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output redundant_poly_L3       o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  redundant_poly_L3 r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count != (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/pairing_host_loader.sv
// Host sequencer for the pairing core: loads operands over extin, pulses run,
// waits for endflag (with timeout), then drains results over extout to a stream.
module pairing_host_loader
  import pairing_host_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2,
  parameter int TIMEOUT    = 2**20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       func,
  input  addr_t            in_base,
  input  addr_t            out_base,
  input  addr_t            in_count,
  input  addr_t            out_count,
  input  logic             s_valid,
  input  redundant_poly_L3 s_data,
  output logic             s_ready,
  output logic             m_valid,
  output redundant_poly_L3 m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy_o,
  output logic             done,
  output logic             err,
  output logic             core_run,
  output logic [3:0]       core_n_func,
  output logic             core_extin_en,
  output addr_t            core_extin_addr,
  output redundant_poly_L3 core_extin_data,
  output addr_t            core_extout_addr,
  input  redundant_poly_L3 core_extout_data,
  input  logic             core_endflag,
  input  logic             core_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  host_state_t      r_state;
  logic [3:0]       r_func;
  addr_t            r_in_base;
  addr_t            r_out_base;
  addr_t            r_in_count;
  addr_t            r_out_count;
  addr_t            r_k;
  addr_t            r_j;
  addr_t            r_popped;
  addr_t            r_ext_addr;
  logic [RD_LAT-1:0] r_vld;
  logic [TW-1:0]    r_timer;
  logic             r_run;
  logic             r_done;
  logic             r_err;

  logic             w_beat;
  logic             w_issue;
  logic             w_pop;
  logic [CW-1:0]    w_fifo_count;
  logic [CW-1:0]    w_inflight;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_vld[i]);
  end

  // Credit counts reads still in the RAM pipeline so a stalled sink can never overflow the FIFO.
  assign w_beat  = (r_state == ST_LOAD) && s_valid;
  assign w_issue = (r_state == ST_DRAIN) && (r_j != r_out_count) &&
                   (({1'b0, w_fifo_count} + {1'b0, w_inflight}) < (CW+1)'(FIFO_DEPTH));
  assign w_pop   = m_valid && m_ready;

  assign s_ready          = (r_state == ST_LOAD);
  assign core_extin_en    = w_beat;
  assign core_extin_addr  = w_beat ? (r_in_base + r_k) : '0;
  assign core_extin_data  = w_beat ? s_data : '0;
  assign core_extout_addr = w_issue ? (r_out_base + r_j) : r_ext_addr;
  assign m_last           = m_valid && (r_popped == (r_out_count - addr_t'(1)));
  assign busy_o           = (r_state != ST_IDLE);
  assign done             = r_done;
  assign err              = r_err;
  assign core_run         = r_run;
  assign core_n_func      = r_func;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_func      <= '0;
      r_in_base   <= '0;
      r_out_base  <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
      r_k         <= '0;
      r_j         <= '0;
      r_popped    <= '0;
      r_ext_addr  <= '0;
      r_vld       <= '0;
      r_timer     <= '0;
      r_run       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_vld[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
      if (w_issue) begin
        r_ext_addr <= core_extout_addr;
        r_j        <= r_j + addr_t'(1);
      end
      if (w_pop) r_popped <= r_popped + addr_t'(1);

      case (r_state)
        ST_IDLE: if (start) begin
          r_func      <= func;
          r_in_base   <= in_base;
          r_out_base  <= out_base;
          r_in_count  <= in_count;
          r_out_count <= out_count;
          r_k         <= '0;
          r_j         <= '0;
          r_popped    <= '0;
          r_err       <= 1'b0;
          if (in_count == '0) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: if (w_beat) begin
          r_k <= r_k + addr_t'(1);
          if (r_k == (r_in_count - addr_t'(1))) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end
        end
        ST_RUN: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_timer <= r_timer + TW'(1);
          // A zero timer marks the first WAIT cycle, where endflag may still be stale.
          if ((r_timer != '0) && core_endflag && !core_busy) begin
            r_state <= (r_out_count == '0) ? ST_DONE : ST_DRAIN;
            r_done  <= (r_out_count == '0);
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DRAIN: if (w_pop && (r_popped == (r_out_count - addr_t'(1)))) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (r_vld[RD_LAT-1]),
    .i_data  (core_extout_data),
    .i_pop   (w_pop),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_count (w_fifo_count)
  );

endmodule
